// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes, write-FSM states and address decode.
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr);
        return addr >> 2;
    endfunction
endpackage

// File: rtl/axil_regfile_core.sv
// axil_regfile_core: byte-strobed register array with one-hot write/read decode.
// AXIL_REGFILE_SLVERR_EN: out-of-range indices select nothing and raise o_*_oor; otherwise they alias modulo NUM_REGS.
module axil_regfile_core
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_we,
    input  logic [31:0]                    i_widx,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
    input  logic [31:0]                    i_ridx,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic                           o_w_oor,
    output logic                           o_r_oor,
    output logic [NUM_REGS-1:0]            o_wsel,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_q
);
    logic [NUM_REGS*DATA_WIDTH-1:0] r_q;
    logic [NUM_REGS-1:0]            w_wsel;
    logic [31:0]                    w_widx, w_ridx;

`ifdef AXIL_REGFILE_SLVERR_EN
    assign w_widx  = i_widx;
    assign w_ridx  = i_ridx;
    assign o_w_oor = i_widx >= 32'(NUM_REGS);
    assign o_r_oor = i_ridx >= 32'(NUM_REGS);
`else
    assign w_widx  = i_widx % 32'(NUM_REGS);
    assign w_ridx  = i_ridx % 32'(NUM_REGS);
    assign o_w_oor = 1'b0;
    assign o_r_oor = 1'b0;
`endif

    always_comb begin
        w_wsel  = '0;
        o_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wsel[i] = w_widx == 32'(i);
            o_rdata   = o_rdata | (w_ridx == 32'(i) ? r_q[DATA_WIDTH*i +: DATA_WIDTH] : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_q <= '0;
        else if (i_we)
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < DATA_WIDTH/8; b++)
                    if (w_wsel[i] && i_wstrb[b])
                        r_q[DATA_WIDTH*i+8*b +: 8] <= i_wdata[8*b +: 8];

    assign o_wsel  = w_wsel;
    assign o_reg_q = r_q;
endmodule

// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite register-file responder, one outstanding write and read.
// AXIL_REGFILE_SLVERR_EN selects SLVERR on out-of-range accesses instead of aliasing.
module axil_regfile_slave
    import axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;

    wr_state_t           r_state, w_next;
    logic                r_live, r_rvalid;
    logic [AW-1:0]       r_awaddr, w_awaddr;
    logic [DW-1:0]       r_wdata, w_wdata, r_rdata, w_rdata;
    logic [DW/8-1:0]     r_wstrb, w_wstrb;
    logic [1:0]          r_bresp, r_rresp;
    logic [NUM_REGS-1:0] r_pulse, w_wsel;
    logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_w_oor, w_r_oor;
    logic                w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};
    assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_commit = (r_state == W_IDLE && w_aw_hs && w_w_hs) ||
                      (r_state == W_HAVE_AW && w_w_hs) || (r_state == W_HAVE_W && w_aw_hs);
    assign w_awaddr = r_state == W_HAVE_AW ? r_awaddr : S_AXI_AWADDR;
    assign w_wdata  = r_state == W_HAVE_W ? r_wdata : S_AXI_WDATA;
    assign w_wstrb  = r_state == W_HAVE_W ? r_wstrb : S_AXI_WSTRB;

    // r_live keeps the readys low while reset is held and for the first edge after release
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) begin
            r_state <= W_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end

    always_comb
        w_next = w_commit ? W_RESP :
                 (r_state == W_RESP && S_AXI_BREADY) ? W_IDLE :
                 (r_state == W_IDLE && w_aw_hs) ? W_HAVE_AW :
                 (r_state == W_IDLE && w_w_hs) ? W_HAVE_W : r_state;

    always_comb begin
        S_AXI_AWREADY = r_live && (r_state == W_IDLE || r_state == W_HAVE_W);
        S_AXI_WREADY  = r_live && (r_state == W_IDLE || r_state == W_HAVE_AW);
        S_AXI_BVALID  = r_state == W_RESP;
        S_AXI_ARREADY = r_live && !r_rvalid;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
            r_pulse  <= '0;
        end else begin
            if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) r_bresp <= w_w_oor ? RESP_SLVERR : RESP_OKAY;
            r_pulse <= w_commit ? w_wsel : '0;
        end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
            r_rresp  <= w_r_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end

    axil_regfile_core #(.DATA_WIDTH(DW), .NUM_REGS(NUM_REGS)) u_core (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .i_we    (w_commit),
        .i_widx  (addr_to_idx(32'(w_awaddr))),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb),
        .i_ridx  (addr_to_idx(32'(S_AXI_ARADDR))),
        .o_rdata (w_rdata),
        .o_w_oor (w_w_oor),
        .o_r_oor (w_r_oor),
        .o_wsel  (w_wsel),
        .o_reg_q (reg_q)
    );

    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;
    assign reg_wr_pulse = r_pulse;
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: directed AXI4-Lite transactions with hand-computed register contents.
module tb_axil_regfile_slave;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb, pulse;
    logic [1:0]   bresp, rresp;
    logic [127:0] reg_q;
    int           n_chk = 0;
    int           n_fail = 0;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0]  OOR_RESP  = 2'b10;
    localparam logic [3:0]  OOR_PULSE = 4'b0000;
    localparam logic [31:0] OOR_RDATA = 32'h0;
    localparam logic [31:0] R0_FINAL  = 32'h11BB33DD;
`else
    localparam logic [1:0]  OOR_RESP  = 2'b00;
    localparam logic [3:0]  OOR_PULSE = 4'b0001;
    localparam logic [31:0] OOR_RDATA = 32'h55;
    localparam logic [31:0] R0_FINAL  = 32'h55;
`endif

    always #5 clk = ~clk;

    axil_regfile_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q), .reg_wr_pulse(pulse)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] er, input logic [3:0] ep, input int hold);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 20) begin
            tick();
            n++;
        end
        check("wr_ready", 128'(n < 20), 128'(1));
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid", 128'(bvalid), 128'(1));
        check("bresp", 128'(bresp), 128'(er));
        check("wr_pulse", 128'(pulse), 128'(ep));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("b_hold", 128'({bvalid, bresp, awready, wready}), 128'({1'b1, er, 2'b00}));
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_done", 128'({bvalid, pulse}), 128'(0));
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er, input int hold);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        check("rd_ready", 128'(n < 20), 128'(1));
        tick();
        arvalid = 1'b0;
        check("r_beat", 128'({rvalid, rresp, rdata}), 128'({1'b1, er, ed}));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_hold", 128'({rvalid, rresp, rdata, arready}), 128'({1'b1, er, ed, 1'b0}));
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_done", 128'({rvalid, rdata}), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        tick(); tick();
        check("rst_ready", 128'({awready, wready, arready}), 128'(0));
        check("rst_valid", 128'({bvalid, rvalid, bresp, rresp}), 128'(0));
        check("rst_rdata", 128'(rdata), 128'(0));
        check("rst_regs", reg_q, 128'(0));
        check("rst_pulse", 128'(pulse), 128'(0));
        rst_n = 1'b1;
        tick(); tick();

        wr(5'h00, 32'h1, 4'hF, 2'b00, 4'b0001, 0);
        wr(5'h04, 32'h2, 4'hF, 2'b00, 4'b0010, 0);
        wr(5'h08, 32'h3, 4'hF, 2'b00, 4'b0100, 0);
        wr(5'h0C, 32'h4, 4'hF, 2'b00, 4'b1000, 0);
        check("seq_regq", reg_q, {32'h4, 32'h3, 32'h2, 32'h1});
        rd(5'h00, 32'h1, 2'b00, 0);
        rd(5'h04, 32'h2, 2'b00, 0);
        rd(5'h08, 32'h3, 2'b00, 0);
        rd(5'h0C, 32'h4, 2'b00, 0);

        // W arrives three cycles before AW
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("split_have_w", 128'({awready, wready, bvalid}), 128'(3'b100));
        tick(); tick();
        check("split_early_pulse", 128'({pulse, bvalid}), 128'(0));
        awaddr = 5'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("split_b", 128'({bvalid, bresp}), 128'(3'b100));
        check("split_pulse", 128'(pulse), 128'(4'b0100));
        check("split_reg2", reg_q[95:64], 128'(32'hDEADBEEF));
        tick();
        check("split_single_pulse", 128'({pulse, bvalid}), 128'(5'b00001));
        bready = 1'b1;
        tick();
        bready = 1'b0;

        wr(5'h00, 32'h11223344, 4'hF, 2'b00, 4'b0001, 0);
        wr(5'h00, 32'hAABBCCDD, 4'b0101, 2'b00, 4'b0001, 0);
        check("strb_reg0", 128'(reg_q[31:0]), 128'(32'h11BB33DD));
        rd(5'h00, 32'h11BB33DD, 2'b00, 0);

        wr(5'h04, 32'h12345678, 4'hF, 2'b00, 4'b0010, 5);
        rd(5'h04, 32'h12345678, 2'b00, 5);
        wr(5'h04, 32'hFFFFFFFF, 4'b0000, 2'b00, 4'b0010, 0);
        check("strb0_reg1", 128'(reg_q[63:32]), 128'(32'h12345678));

        wr(5'h10, 32'h55, 4'hF, OOR_RESP, OOR_PULSE, 0);
        check("oor_reg0", 128'(reg_q[31:0]), 128'(R0_FINAL));
        check("oor_others", 128'(reg_q[127:32]), 128'({32'h4, 32'hDEADBEEF, 32'h12345678}));
        rd(5'h10, OOR_RDATA, OOR_RESP, 0);
        rd(5'h00, R0_FINAL, 2'b00, 0);

        // write commit and read handshake to reg3 on the same edge
        awaddr = 5'h0C; wdata = 32'h77; wstrb = 4'hF; araddr = 5'h0C;
        check("same_ready", 128'({awready, wready, arready}), 128'(3'b111));
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_old_rdata", 128'({rvalid, rdata}), 128'({1'b1, 32'h4}));
        check("same_new_reg3", 128'({bvalid, reg_q[127:96]}), 128'({1'b1, 32'h77}));
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;

        // asynchronous reset while waiting in W_HAVE_AW
        awaddr = 5'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("have_aw", 128'({awready, wready}), 128'(2'b01));
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 128'({awready, wready, arready, bvalid, rvalid}), 128'(0));
        check("arst_regs", reg_q, 128'(0));
        check("arst_misc", 128'({pulse, bresp, rresp, rdata}), 128'(0));
        tick();
        rst_n = 1'b1;
        tick(); tick();
        wr(5'h04, 32'h99, 4'hF, 2'b00, 4'b0010, 0);
        rd(5'h04, 32'h99, 2'b00, 0);
        check("post_rst_regq", reg_q, {32'h0, 32'h0, 32'h99, 32'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
